nixie_scan_driver: RTL and testbench



---
 rtl/nixie_scan_driver_pkg.sv | 24 ++
 rtl/nixie_scan_driver_bcd.sv | 34 +++
 rtl/nixie_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_nixie_scan_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nixie_scan_driver_pkg.sv
// Shared constants and types for the nixie scan driver.
// Slot map, legal maxima, output field positions, scan FSM states.
`timescale 1ns/1ps
package nixie_scan_driver_pkg;
  localparam int NUM_SLOTS      = 6;
  localparam int SLOT_SEC_ONES  = 0;
  localparam int SLOT_SEC_TENS  = 1;
  localparam int SLOT_MIN_ONES  = 2;
  localparam int SLOT_MIN_TENS  = 3;
  localparam int SLOT_HOUR_ONES = 4;
  localparam int SLOT_HOUR_TENS = 5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int DIGIT_LSB = 0;
  localparam int VALID_BIT = 4;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_e;
endpackage

// File: rtl/nixie_scan_driver_bcd.sv
// 6-bit binary to two BCD digits via a compare/subtract chain.
// Ports: bin_i value in; tens_o/ones_o digits; valid_o = bin_i <= MAX.
`timescale 1ns/1ps
module bin_to_bcd_2digit #(
  parameter int MAX = 59
) (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       valid_o
);
  logic [5:0] r;
  logic [3:0] t;

  always_comb begin
    r = bin_i;
    t = 4'd0;
    if (r >= 6'd40) begin
      r = r - 6'd40;
      t = t + 4'd4;
    end
    if (r >= 6'd20) begin
      r = r - 6'd20;
      t = t + 4'd2;
    end
    if (r >= 6'd10) begin
      r = r - 6'd10;
      t = t + 4'd1;
    end
    tens_o  = t;
    ones_o  = r[3:0];
    valid_o = (bin_i <= 6'(MAX));
  end
endmodule

// File: rtl/nixie_scan_driver.sv
// Six-tube multiplexed nixie driver: snapshot per scan, BCD, blanking gaps,
// minute-change cathode scrub. Ports: clk, rst (sync, high), second/minute/
// hour in; nixieEnable one-hot anode, nixieValue {000, valid, bcd}.
`timescale 1ns/1ps
module nixie_scan_driver
  import nixie_scan_driver_pkg::*;
#(
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 10000,
  parameter int SCRUB_SCANS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] second,
  input  logic [5:0] minute,
  input  logic [5:0] hour,
  output logic [5:0] nixieEnable,
  output logic [7:0] nixieValue
);
  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int SW   = $clog2(SCRUB_SCANS + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      slot_q, slot_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      hour_q, hour_d;
  logic            first_q, first_d;
  logic            scrub_q, scrub_d;
  logic [3:0]      sdig_q, sdig_d;
  logic [SW-1:0]   scnt_q, scnt_d;

  logic            last;
  logic            snap;
  logic            min_chg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    first_d = first_q;
    scrub_d = scrub_q;
    sdig_d  = sdig_q;
    scnt_d  = scnt_q;

    if (state_q == BLANK) last = (cnt_q == CW'(BLANK_CYCLES - 1));
    else                  last = (cnt_q == CW'(ON_CYCLES - 1));

    if (last) begin
      cnt_d = '0;
      if (state_q == BLANK) begin
        state_d = ON;
      end else begin
        state_d = BLANK;
        slot_d  = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Snapshot on reset exit and on every entry to BLANK for slot 0.
    snap    = first_q | ((state_q == ON) & last & (slot_q == 3'd5));
    min_chg = (minute != min_q) | (minute > 6'(MIN_MAX));

    if (snap) begin
      sec_d   = second;
      min_d   = minute;
      hour_d  = hour;
      first_d = 1'b0;
      if (scrub_q) begin
        // A scan just completed under scrub; minute changes are ignored.
        if (scnt_q == SW'(SCRUB_SCANS - 1)) begin
          scnt_d = '0;
          if (sdig_q == 4'd9) scrub_d = 1'b0;
          else                sdig_d  = sdig_q + 4'd1;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end else if (!first_q && min_chg) begin
        scrub_d = 1'b1;
        sdig_d  = 4'd0;
        scnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      slot_q  <= 3'd0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      first_q <= 1'b1;
      scrub_q <= 1'b0;
      sdig_q  <= 4'd0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      first_q <= first_d;
      scrub_q <= scrub_d;
      sdig_q  <= sdig_d;
      scnt_q  <= scnt_d;
    end
  end

  logic [3:0] s_t, s_o, m_t, m_o, h_t, h_o;
  logic       s_v, m_v, h_v;

  bin_to_bcd_2digit #(.MAX(SEC_MAX)) u_sec (
    .bin_i(sec_q), .tens_o(s_t), .ones_o(s_o), .valid_o(s_v)
  );
  bin_to_bcd_2digit #(.MAX(MIN_MAX)) u_min (
    .bin_i(min_q), .tens_o(m_t), .ones_o(m_o), .valid_o(m_v)
  );
  bin_to_bcd_2digit #(.MAX(HOUR_MAX)) u_hour (
    .bin_i(hour_q), .tens_o(h_t), .ones_o(h_o), .valid_o(h_v)
  );

  logic [3:0] dig;
  logic       vld;
  logic       show;

  always_comb begin
    dig = 4'd0;
    vld = 1'b0;
    case (slot_q)
      3'(SLOT_SEC_ONES):  begin dig = s_o; vld = s_v; end
      3'(SLOT_SEC_TENS):  begin dig = s_t; vld = s_v; end
      3'(SLOT_MIN_ONES):  begin dig = m_o; vld = m_v; end
      3'(SLOT_MIN_TENS):  begin dig = m_t; vld = m_v; end
      3'(SLOT_HOUR_ONES): begin dig = h_o; vld = h_v; end
      3'(SLOT_HOUR_TENS): begin dig = h_t; vld = h_v; end
      default:            begin dig = 4'd0; vld = 1'b0; end
    endcase
    if (scrub_q) begin
      dig = sdig_q;
      vld = 1'b1;
    end
    // Nothing is shown until the first snapshot has been taken.
    show = vld & ~first_q;

    nixieValue = 8'd0;
    nixieValue[VALID_BIT] = show;
    nixieValue[DIGIT_LSB +: 4] = show ? dig : 4'd0;

    nixieEnable = 6'd0;
    if ((state_q == ON) && show) nixieEnable = 6'b1 << slot_q;
  end
endmodule

// File: tb/tb_nixie_scan_driver.sv
// Self-checking bench for nixie_scan_driver with ON=8, BLANK=2, SCRUB=2.
// Directed vector table plus a hand sequence for mid-scrub reset.
`timescale 1ns/1ps
module tb_nixie_scan_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] second = 6'd7;
  logic [5:0] minute = 6'd45;
  logic [5:0] hour = 6'd13;
  logic [5:0] nixieEnable;
  logic [7:0] nixieValue;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  nixie_scan_driver #(
    .ON_CYCLES(8), .BLANK_CYCLES(2), .SCRUB_SCANS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .second(second), .minute(minute), .hour(hour),
    .nixieEnable(nixieEnable), .nixieValue(nixieValue)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < c && guard < 4000);
    n_tests++;
    if (cyc != c) begin
      n_fail++;
      $display("FAIL wait_cyc: got cycle %0d want %0d", cyc, c);
    end
  endtask

  // Anode safety: at most one tube lit, >= 2 dark cycles between tubes.
  logic [5:0] last_nz = 6'd0;
  logic [5:0] prev_en = 6'd0;
  int         zrun    = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_nz = 6'd0;
      prev_en = 6'd0;
      zrun    = 0;
    end else begin
      n_tests++;
      if ($countones(nixieEnable) > 1) begin
        n_fail++;
        $display("FAIL onehot: got %b want <=1 bit", nixieEnable);
      end
      if (nixieEnable == 6'd0) begin
        zrun++;
      end else begin
        if (prev_en == 6'd0 && last_nz != 6'd0) begin
          n_tests++;
          if (zrun < 2) begin
            n_fail++;
            $display("FAIL gap: got %0d dark cycles want >=2", zrun);
          end
        end
        last_nz = nixieEnable;
        zrun    = 0;
      end
      prev_en = nixieEnable;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         scan;
    int         slot;
    logic [5:0] en;
    logic [7:0] val;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Normal scans, 13:45:07 then :08.
    tbl.push_back('{0, 0, 6'h01, 8'h17});
    tbl.push_back('{0, 1, 6'h02, 8'h10});
    tbl.push_back('{0, 2, 6'h04, 8'h15});
    tbl.push_back('{0, 3, 6'h08, 8'h14});
    tbl.push_back('{0, 4, 6'h10, 8'h13});
    tbl.push_back('{0, 5, 6'h20, 8'h11});
    tbl.push_back('{1, 0, 6'h01, 8'h18});
    tbl.push_back('{1, 2, 6'h04, 8'h15});
    // Scrub from scan 2, each digit held 2 scans.
    tbl.push_back('{2, 0, 6'h01, 8'h10});
    tbl.push_back('{2, 5, 6'h20, 8'h10});
    tbl.push_back('{3, 3, 6'h08, 8'h10});
    tbl.push_back('{4, 0, 6'h01, 8'h11});
    tbl.push_back('{7, 2, 6'h04, 8'h12});
    tbl.push_back('{8, 1, 6'h02, 8'h13});
    tbl.push_back('{20, 4, 6'h10, 8'h19});
    tbl.push_back('{21, 0, 6'h01, 8'h19});
    // Scrub over, 13:47:08.
    tbl.push_back('{22, 0, 6'h01, 8'h18});
    tbl.push_back('{22, 2, 6'h04, 8'h17});
    tbl.push_back('{22, 3, 6'h08, 8'h14});
    tbl.push_back('{22, 5, 6'h20, 8'h11});
    tbl.push_back('{23, 2, 6'h04, 8'h17});
    // Illegal hour 30: hour pair dark.
    tbl.push_back('{24, 0, 6'h01, 8'h18});
    tbl.push_back('{24, 3, 6'h08, 8'h14});
    tbl.push_back('{24, 4, 6'h00, 8'h00});
    tbl.push_back('{24, 5, 6'h00, 8'h00});
    // Scrub lights the illegal pair too.
    tbl.push_back('{25, 0, 6'h01, 8'h10});
    tbl.push_back('{25, 4, 6'h10, 8'h10});
    tbl.push_back('{25, 5, 6'h20, 8'h10});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    fork
      begin
        wait_cyc(20);   second = 6'd8;
        wait_cyc(70);   minute = 6'd46;
        wait_cyc(390);  minute = 6'd47;
        wait_cyc(1410); hour   = 6'd30;
        wait_cyc(1470); minute = 6'd48;
      end
    join_none

    wait_cyc(0);
    chk("rst_exit en c0", {2'b0, nixieEnable}, 8'h00);
    chk("rst_exit val c0", nixieValue, 8'h00);
    wait_cyc(1);
    chk("rst_exit en c1", {2'b0, nixieEnable}, 8'h00);

    foreach (tbl[i]) begin
      for (int k = 2; k <= 9; k += 7) begin
        wait_cyc(tbl[i].scan * 60 + tbl[i].slot * 10 + k);
        chk($sformatf("s%0d.%0d+%0d en", tbl[i].scan, tbl[i].slot, k),
            {2'b0, nixieEnable}, {2'b0, tbl[i].en});
        chk($sformatf("s%0d.%0d+%0d val", tbl[i].scan, tbl[i].slot, k),
            nixieValue, tbl[i].val);
      end
    end

    // Reset mid-ON of slot 3 during scrub (scan 26, digit 0).
    wait_cyc(26 * 60 + 34);
    chk("pre_rst en", {2'b0, nixieEnable}, 8'h08);
    chk("pre_rst val", nixieValue, 8'h10);
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst en", {2'b0, nixieEnable}, 8'h00);
    chk("in_rst val", nixieValue, 8'h00);
    rst  = 1'b0;
    hour = 6'd13;
    wait_cyc(1);
    chk("post_rst en c1", {2'b0, nixieEnable}, 8'h00);
    wait_cyc(2);
    chk("post_rst en c2", {2'b0, nixieEnable}, 8'h01);
    chk("post_rst val c2", nixieValue, 8'h18);
    wait_cyc(42);
    chk("post_rst hour en", {2'b0, nixieEnable}, 8'h10);
    chk("post_rst hour val", nixieValue, 8'h13);
    wait_cyc(62);
    chk("post_rst scan1 en", {2'b0, nixieEnable}, 8'h01);
    chk("post_rst scan1 val", nixieValue, 8'h18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
